dmem_mmio: RTL
==============

Name: dmem_mmio

Overview:
Data-side memory and memory-mapped I/O unit sitting directly downstream of the single-cycle RISC-V core. It consumes the core's MemWrite, ALUResult (as address) and WriteData, and returns ReadData in the same cycle. It contains a word-addressed data RAM, an LED output register, a synchronized switch input and a prescaled 32-bit timer with compare match and sticky interrupt flag.

Parameters:
DEPTH, 64, number of 32-bit RAM words (power of 2, at least 4)
NLED, 10, width of LED output register
NSW, 10, width of switch input
PRESCALE, 1, clock cycles per timer tick (1 = tick every cycle; at least 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
MemWrite  input  1  store strobe from core; write commits at next rising clk
ALUResult  input  32  byte address from core; bits [1:0] ignored (word access only)
WriteData  input  32  store data from core
ReadData  output  32  load data, combinational from ALUResult and current state
Switches  input  NSW  asynchronous board switches
Leds  output  NLED  LED register contents
TimerIrq  output  1  STATUS.match AND CTRL.irq_en, registered-state driven

Behaviour:
- Address map (word index = ALUResult[31:2]):
  - RAM: ALUResult[31]=0 and ALUResult[30:2] < DEPTH; index ALUResult[log2(DEPTH)+1:2]. Addresses with ALUResult[31]=0 beyond DEPTH are unmapped.
  - 0x8000_0000 LED (RW, low NLED bits; upper read 0)
  - 0x8000_0004 SW (RO, synchronized switches, upper bits 0)
  - 0x8000_0008 COUNT (RW)
  - 0x8000_000C COMPARE (RW)
  - 0x8000_0010 STATUS (bit0 match, sticky; write 1 clears, write 0 no effect; other bits read 0)
  - 0x8000_0014 CTRL (bit0 en, bit1 autoclr, bit2 irq_en; other bits read 0, ignored on write)
  - Unmapped: read returns 0x0000_0000; writes ignored, no side effects.
- Reads: purely combinational, zero latency, so the single-cycle core sees data in the same cycle. Reads have no side effects.
- Writes: occur only on a rising clk with MemWrite=1. Read-after-write to the same address returns the new value from the next cycle.
- Reset (rst=1 at rising edge): Leds=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, CTRL=0, prescaler=0, synchronizer flops=0, TimerIrq=0. RAM contents are not reset and stay undefined until written. Reset has priority over any write in the same cycle.
- Switch path: two-flop synchronizer, so SW reads reflect a Switches change after 2 rising edges.
- Timer:
  - Prescaler counts 0..PRESCALE-1 while CTRL.en=1. A tick happens in the cycle the prescaler is at PRESCALE-1, after which it returns to 0.
  - When CTRL.en=0, the prescaler and COUNT hold.
  - On a tick, if COUNT==COMPARE: STATUS.match is set, and COUNT becomes 0 if autoclr=1, otherwise COUNT+1.
  - On a tick with no match: COUNT becomes COUNT+1, wrapping 0xFFFF_FFFF to 0 with no flag.
- Priority and simultaneous events:
  - A COUNT write beats a same-cycle tick: COUNT takes WriteData and the prescaler resets to 0.
  - A match-set beats a same-cycle W1C: the flag stays 1.
  - A COMPARE write takes effect for ticks from the next cycle on.
  - A CTRL write clearing en freezes the timer in the same edge; no tick is applied.
- TimerIrq is combinational from the registered STATUS.match and CTRL.irq_en. It is level, not pulse, and stays asserted until W1C or irq_en=0.

Test Plan:
- Reset, then read each MMIO address -> LED=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, CTRL=0, TimerIrq=0.
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 next cycle -> 0xDEADBEEF. Store to 0x0000_0013 hits the same word. Load 0x0000_4000 (DEPTH=64) -> 0. Store 0x8000_0040 -> no register changes.
- Store 0x3FF to LED -> Leds=0x3FF after the edge. Set Switches=0x155 -> SW reads 0 for 1 cycle after the change, then 0x155 from the 2nd edge onward.
- PRESCALE=1: COMPARE=5, CTRL=0b111, COUNT=0 -> match on the 6th enabled cycle, COUNT returns to 0, TimerIrq=1. Write STATUS=1 -> TimerIrq=0 next cycle.
- Match tick and W1C in the same cycle -> STATUS.match stays 1. COUNT write of 100 in a tick cycle -> COUNT=100 (no +1).
- PRESCALE=4, autoclr=0, COUNT=0xFFFF_FFFF, COMPARE=7 -> COUNT=0 after 4 cycles, no match. Assert rst mid-count -> all registers return to reset values on that edge.

Source files
------------

// File: rtl/dmem_mmio_if.sv
// Core-side data bus: store strobe, byte address, store data and same-cycle load data.
interface dmem_mmio_if;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_write, alu_result, write_data, input read_data);
  modport slave  (input mem_write, alu_result, write_data, output read_data);
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus memory-mapped LEDs, synchronized switches and a prescaled compare timer.
// Loads are combinational; all state changes on the rising clock edge.
module dmem_mmio #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned NLED     = 10,
  parameter int unsigned NSW      = 10,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_mmio_if.slave      bus,
  input  logic [NSW-1:0]  switches,
  output logic [NLED-1:0] leds,
  output logic            timer_irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);

  logic [31:0]     mem [DEPTH];
  logic [NLED-1:0] leds_q, leds_d;
  logic [NSW-1:0]  sync1_q, sync2_q;
  logic [31:0]     count_q, count_d;
  logic [31:0]     compare_q, compare_d;
  logic            match_q, match_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [PW-1:0]   presc_q, presc_d;

  logic       ram_hit, mmio_hit;
  logic [2:0] reg_sel;
  logic       wr_ram, wr_led, wr_count, wr_compare, wr_status, wr_ctrl;
  logic       en_eff, tick, match_hit;
  logic       unused_addr;

  assign ram_hit  = ~bus.alu_result[31] && (bus.alu_result[30:AW+2] == '0);
  assign mmio_hit = bus.alu_result[31] && (bus.alu_result[30:5] == '0);
  assign reg_sel  = bus.alu_result[4:2];
  assign unused_addr = ^bus.alu_result[1:0];

  assign wr_ram     = bus.mem_write & ram_hit;
  assign wr_led     = bus.mem_write & mmio_hit & (reg_sel == 3'd0);
  assign wr_count   = bus.mem_write & mmio_hit & (reg_sel == 3'd2);
  assign wr_compare = bus.mem_write & mmio_hit & (reg_sel == 3'd3);
  assign wr_status  = bus.mem_write & mmio_hit & (reg_sel == 3'd4);
  assign wr_ctrl    = bus.mem_write & mmio_hit & (reg_sel == 3'd5);

  // A CTRL store that clears en must stop the timer on this same edge.
  assign en_eff    = ctrl_q[0] & ~(wr_ctrl & ~bus.write_data[0]);
  assign tick      = en_eff & (presc_q == PrescLast);
  assign match_hit = tick & (count_q == compare_q);

  always_comb begin
    leds_d    = leds_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    count_d   = count_q;
    match_d   = match_q;
    if (wr_led)     leds_d    = bus.write_data[NLED-1:0];
    if (wr_compare) compare_d = bus.write_data;
    if (wr_ctrl)    ctrl_d    = bus.write_data[2:0];
    if (en_eff)     presc_d   = tick ? '0 : presc_q + 1'b1;
    if (tick)       count_d   = (match_hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    if (wr_count) begin
      count_d = bus.write_data;
      presc_d = '0;
    end
    // Set wins over a same-cycle write-1-to-clear.
    if (wr_status && bus.write_data[0]) match_d = 1'b0;
    if (match_hit)                      match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
      ctrl_q    <= '0;
      presc_q   <= '0;
    end else begin
      leds_q    <= leds_d;
      sync1_q   <= switches;
      sync2_q   <= sync1_q;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ram) mem[bus.alu_result[AW+1:2]] <= bus.write_data;
  end

  always_comb begin
    bus.read_data = 32'd0;
    if (ram_hit) begin
      bus.read_data = mem[bus.alu_result[AW+1:2]];
    end else if (mmio_hit) begin
      case (reg_sel)
        3'd0:    bus.read_data = 32'(leds_q);
        3'd1:    bus.read_data = 32'(sync2_q);
        3'd2:    bus.read_data = count_q;
        3'd3:    bus.read_data = compare_q;
        3'd4:    bus.read_data = {31'd0, match_q};
        3'd5:    bus.read_data = {29'd0, ctrl_q};
        default: bus.read_data = 32'd0;
      endcase
    end
  end

  assign leds      = leds_q;
  assign timer_irq = match_q & ctrl_q[2];

endmodule
